// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM encoding and
// front-end defaults.
package cpu_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    OUT  = ST_OUT,
    DROP = ST_DROP
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if_out_buf.sv
// One-entry holding register between fetch and decode.
// Flush wins over load; load wins over drain.
module if_out_buf
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [31:0]       load_instr,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // next contents: flush, capture or hand-off
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, single-outstanding imem read,
// redirect handling and hand-off to decode.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              buf_load;
  logic              buf_flush;

  // next state, PC and request outputs; redirect last
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    imem_req_valid = 1'b0;
    imem_addr      = pc_q;
    buf_load       = 1'b0;
    buf_flush      = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          req_pc_d = pc_q;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          buf_load = 1'b1;
          pc_d     = req_pc_q + ADDR_W'(1);
          state_d  = OUT;
        end
      end
      OUT: begin
        if (if_valid && if_ready) state_d = REQ;
      end
      DROP: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      imem_addr = redirect_pc;
      buf_load  = 1'b0;
      buf_flush = 1'b1;
      unique case (state_q)
        WAIT: state_d = imem_rsp_valid ? REQ : DROP;
        REQ:  state_d = imem_req_ready ? DROP : REQ;
        DROP: state_d = imem_rsp_valid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  // FSM and PC registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  if_out_buf #(
    .ADDR_W(ADDR_W)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_instr(imem_rsp_data),
    .load_pc   (req_pc_q),
    .flush     (buf_flush),
    .out_ready (if_ready),
    .out_valid (if_valid),
    .out_instr (if_instr),
    .out_pc    (if_pc)
  );

endmodule
